// File: rtl/note_arbiter_if.sv
// Song-note handshake between the song ROM sequencer (master) and the
// buzzer arbiter (slave).
interface note_arbiter_if #(
  parameter int NOTE_W = 8,
  parameter int DUR_W  = 8
);
  logic              valid;
  logic [NOTE_W-1:0] note;
  logic [DUR_W-1:0]  dur;
  logic              ready;

  modport master (output valid, note, dur, input ready);
  modport slave  (input valid, note, dur, output ready);
endinterface

// File: rtl/note_arbiter.sv
// Shares the single buzzer datapath between live keyboard notes (priority)
// and song playback, timing every note in prescaled ticks plus a silent gap.
module note_arbiter #(
  parameter int NOTE_W    = 8,
  parameter int DUR_W     = 8,
  parameter int TICK_DIV  = 50000,
  parameter int KEY_HOLD  = 20,
  parameter int GAP_TICKS = 1
) (
  input  logic              iClk,
  input  logic              iReset,
  input  logic              iKey_Valid,
  input  logic [NOTE_W-1:0] iKey_Note,
  note_arbiter_if.slave     song,
  input  logic              iPause,
  output logic [NOTE_W-1:0] oFreq_Data,
  output logic              oRing,
  output logic [1:0]        oSource,
  output logic              oNote_Done,
  output logic              oPreempt
);

  localparam int PRE_W  = $clog2(TICK_DIV);
  localparam int KH_W   = $clog2(KEY_HOLD + 1);
  localparam int GAP_W  = $clog2(GAP_TICKS + 1);
  localparam int MAX_A  = (KH_W > GAP_W) ? KH_W : GAP_W;
  localparam int TMR_W  = (DUR_W > MAX_A) ? DUR_W : MAX_A;

  localparam logic [PRE_W-1:0] PRE_MAX  = PRE_W'(TICK_DIV - 1);
  localparam logic [TMR_W-1:0] KEY_LOAD = TMR_W'(KEY_HOLD);
  localparam logic [TMR_W-1:0] GAP_LOAD = TMR_W'(GAP_TICKS);
  localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);

  localparam logic [1:0] SRC_NONE = 2'd0;
  localparam logic [1:0] SRC_KEY  = 2'd1;
  localparam logic [1:0] SRC_SONG = 2'd2;

  typedef enum logic [1:0] {IDLE, KEY, SONG, GAP} state_t;

  state_t            stateReg;
  logic [PRE_W-1:0]  prescaleReg;
  logic [TMR_W-1:0]  timerReg;

  logic              tick;
  logic              lastTick;
  logic              songTake;
  logic [PRE_W-1:0]  prescaleNext;
  logic [TMR_W-1:0]  songTicks;

  assign song.ready   = (stateReg == IDLE) && !iPause && !iKey_Valid;
  assign songTake     = song.valid && song.ready;
  assign tick         = (prescaleReg == PRE_MAX);
  assign lastTick     = tick && (timerReg == TMR_ONE);
  assign prescaleNext = tick ? '0 : prescaleReg + PRE_W'(1);
  // A zero duration still sounds for one full tick.
  assign songTicks    = (song.dur == '0) ? TMR_ONE : TMR_W'(song.dur);

  always_ff @(posedge iClk) begin
    if (iReset) begin
      stateReg    <= IDLE;
      prescaleReg <= '0;
      timerReg    <= '0;
      oFreq_Data  <= '0;
      oRing       <= 1'b0;
      oSource     <= SRC_NONE;
      oNote_Done  <= 1'b0;
      oPreempt    <= 1'b0;
    end else begin
      oNote_Done <= 1'b0;
      oPreempt   <= 1'b0;
      // Key presses win in every state; a retrigger in KEY reloads without a gap.
      if (iKey_Valid) begin
        stateReg    <= KEY;
        prescaleReg <= '0;
        timerReg    <= KEY_LOAD;
        oFreq_Data  <= iKey_Note;
        oRing       <= (iKey_Note != '0);
        oSource     <= SRC_KEY;
        oPreempt    <= (stateReg == SONG);
      end else begin
        case (stateReg)
          IDLE: begin
            if (songTake) begin
              stateReg    <= SONG;
              prescaleReg <= '0;
              timerReg    <= songTicks;
              oFreq_Data  <= song.note;
              oRing       <= (song.note != '0);
              oSource     <= SRC_SONG;
            end
          end
          KEY: begin
            if (lastTick) begin
              stateReg    <= GAP;
              prescaleReg <= '0;
              timerReg    <= GAP_LOAD;
              oFreq_Data  <= '0;
              oRing       <= 1'b0;
              oSource     <= SRC_NONE;
            end else begin
              prescaleReg <= prescaleNext;
              if (tick) timerReg <= timerReg - TMR_ONE;
            end
          end
          SONG: begin
            if (iPause) begin
              oRing <= 1'b0;
            end else if (lastTick) begin
              stateReg    <= GAP;
              prescaleReg <= '0;
              timerReg    <= GAP_LOAD;
              oFreq_Data  <= '0;
              oRing       <= 1'b0;
              oSource     <= SRC_NONE;
              oNote_Done  <= 1'b1;
            end else begin
              prescaleReg <= prescaleNext;
              oRing       <= (oFreq_Data != '0);
              if (tick) timerReg <= timerReg - TMR_ONE;
            end
          end
          GAP: begin
            if (lastTick) begin
              stateReg    <= IDLE;
              prescaleReg <= '0;
              timerReg    <= '0;
            end else begin
              prescaleReg <= prescaleNext;
              if (tick) timerReg <= timerReg - TMR_ONE;
            end
          end
          default: stateReg <= IDLE;
        endcase
      end
    end
  end

endmodule
